layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/accel_pkg.sv | 15 +
 rtl/act_buffer.sv | 24 ++
 rtl/layer_sequencer.sv | 117 +++++++++++
 tb/tb_layer_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default activation width and the layer
// sequencer state encoding.
package accel_pkg;

  localparam int ACT_DATA_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/act_buffer.sv
// Activation frame buffer: one write port and one registered read port, with
// no reset so that it maps onto block RAM.
module act_buffer #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 784,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: buffers one input frame, streams it element by element into
// the linear datapath, waits out the pipeline drain and holds the result flag.
module layer_sequencer
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH   = ACT_DATA_WIDTH,
  parameter int INPUT_LENGTH = 784,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            dp_valid,
  output logic [DATA_WIDTH-1:0]           dp_din,
  output logic [$clog2(INPUT_LENGTH)-1:0] dp_idx,
  output logic                            dp_clr,
  output logic                            dp_last,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            busy
);

  localparam int IDX_W = $clog2(INPUT_LENGTH);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INPUT_LENGTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYCLES);

  seq_state_t state, state_next;

  logic [IDX_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      drain_cnt;
  logic                  rst_q;
  logic                  accept, issue;
  logic                  dp_valid_q, dp_clr_q, dp_last_q;
  logic [IDX_W-1:0]      dp_idx_q;
  logic [DATA_WIDTH-1:0] rd_data;

  // rst_q keeps the input closed for the cycle right after reset.
  assign s_ready = (state == IDLE || state == LOAD) && !rst && !rst_q;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (accept) state_next = (wr_ptr == LAST_IDX) ? RUN : LOAD;
      end
      RUN: begin
        issue = 1'b1;
        if (rd_ptr == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_END) state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // DRAIN is entered while the last element is still on the dp outputs, so it
  // spans DRAIN_CYCLES+1 cycles of which DRAIN_CYCLES have dp_valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drain_cnt  <= '0;
      rst_q      <= 1'b1;
      dp_valid_q <= 1'b0;
      dp_clr_q   <= 1'b0;
      dp_last_q  <= 1'b0;
      dp_idx_q   <= '0;
    end else begin
      rst_q <= 1'b0;
      if (accept) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (issue)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      dp_valid_q <= issue;
      dp_clr_q   <= issue && (rd_ptr == '0);
      dp_last_q  <= issue && (rd_ptr == LAST_IDX);
      dp_idx_q   <= issue ? rd_ptr : '0;
    end
  end

  act_buffer #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH      (INPUT_LENGTH),
    .ADDR_WIDTH (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // The RAM output is not reset, so dp_din is forced to zero whenever idle.
  assign dp_valid  = dp_valid_q && !rst;
  assign dp_clr    = dp_clr_q && !rst;
  assign dp_last   = dp_last_q && !rst;
  assign dp_idx    = rst ? '0 : dp_idx_q;
  assign dp_din    = (dp_valid_q && !rst) ? rd_data : '0;
  assign res_valid = (state == DONE) && !rst;
  assign busy      = (state != IDLE) && !rst;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer with a 4-word frame: expected elements are queued
// as words are accepted and compared as the datapath stream appears.
module tb_layer_sequencer;

  localparam int DW  = 24;
  localparam int LEN = 4;
  localparam int IW  = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          dp_valid;
  logic [DW-1:0] dp_din;
  logic [IW-1:0] dp_idx;
  logic          dp_clr;
  logic          dp_last;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          busy;

  exp_t sb[$];
  int   wr_cnt    = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   res_count = 0;

  layer_sequencer #(
    .DATA_WIDTH   (DW),
    .INPUT_LENGTH (LEN),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .dp_valid  (dp_valid),
    .dp_din    (dp_din),
    .dp_idx    (dp_idx),
    .dp_clr    (dp_clr),
    .dp_last   (dp_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) res_count++;

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_word(input logic [DW-1:0] d);
    int   n;
    exp_t e;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%b, required 1 within 20 cycles", s_ready);
    end else begin
      e.data = d;
      e.idx  = IW'(wr_cnt);
      sb.push_back(e);
      wr_cnt = (wr_cnt + 1) % LEN;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic collect_elements(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dp_valid !== 1'b1) begin
        errors++;
        $display("FAIL dp_valid_stream: element %0d dp_valid=%b, required 1", i, dp_valid);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: element %0d has no expected entry", i);
      end else begin
        e = sb.pop_front();
        if (dp_din !== e.data) begin
          errors++;
          $display("FAIL dp_din: element %0d got %0d, required %0d", i, dp_din, e.data);
        end
        checks++;
        if (dp_idx !== e.idx) begin
          errors++;
          $display("FAIL dp_idx: element %0d got %0d, required %0d", i, dp_idx, e.idx);
        end
        checks++;
        if (dp_clr !== (e.idx == '0)) begin
          errors++;
          $display("FAIL dp_clr: idx %0d got %b, required %b", e.idx, dp_clr, (e.idx == '0));
        end
        checks++;
        if (dp_last !== (e.idx == IW'(LEN - 1))) begin
          errors++;
          $display("FAIL dp_last: idx %0d got %b, required %b", e.idx, dp_last, (e.idx == IW'(LEN - 1)));
        end
      end
    end
  endtask

  // Checks the cycle after the 4th word: still no element on the datapath.
  task automatic check_first_gap;
    checks++;
    if (dp_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: dp_valid=%b s_ready=%b busy=%b, required 0 0 1", dp_valid, s_ready, busy);
    end
    @(negedge clk);
  endtask

  // From the dp_last cycle: two drain cycles, n_low+1 DONE cycles, then IDLE.
  task automatic drain_and_release(input int n_low, input logic keep);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (dp_valid !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain: cycle %0d dp_valid=%b res_valid=%b, required 0 0", k, dp_valid, res_valid);
      end
    end
    for (int k = 1; k <= n_low + 1; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: cycle %0d res_valid=%b s_ready=%b, required 1 0", k, res_valid, s_ready);
      end
      res_ready = keep || (k == n_low + 1);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: res_valid=%b s_ready=%b busy=%b, required 0 1 0", res_valid, s_ready, busy);
    end
    res_ready = keep;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, dp_valid, dp_clr, dp_last, res_valid, busy} !== 6'b0 || dp_idx !== '0 || dp_din !== '0) begin
      errors++;
      $display("FAIL reset_during: ctl=%b idx=%0d din=%0d, required all 0",
               {s_ready, dp_valid, dp_clr, dp_last, res_valid, busy}, dp_idx, dp_din);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({s_ready, dp_valid, dp_clr, dp_last, res_valid, busy} !== 6'b0 || dp_idx !== '0 || dp_din !== '0) begin
      errors++;
      $display("FAIL reset_after: ctl=%b idx=%0d din=%0d, required all 0",
               {s_ready, dp_valid, dp_clr, dp_last, res_valid, busy}, dp_idx, dp_din);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: s_ready=%b busy=%b, required 1 0", s_ready, busy);
    end
    sb.delete();
    wr_cnt = 0;
  endtask

  task automatic test_stream;
    send_word(24'd10);
    send_word(24'd20);
    send_word(24'd30);
    send_word(24'd40);
    check_first_gap();
    collect_elements(LEN);
    drain_and_release(0, 1'b0);
  endtask

  task automatic test_gaps;
    for (int i = 0; i < LEN; i++) begin
      if (i > 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_word(DW'($urandom));
    end
    check_first_gap();
    collect_elements(LEN);
    drain_and_release(0, 1'b0);
  endtask

  task automatic test_done_hold;
    for (int i = 0; i < LEN; i++) send_word(DW'(100 + i));
    check_first_gap();
    collect_elements(LEN);
    drain_and_release(5, 1'b0);
  endtask

  task automatic test_reset_mid_load;
    send_word(24'd111);
    send_word(24'd222);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    wr_cnt = 0;
    @(negedge clk);
    for (int i = 1; i <= LEN; i++) send_word(DW'(i));
    check_first_gap();
    collect_elements(LEN);
    drain_and_release(0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    int base;
    for (int i = 0; i < LEN; i++) send_word(DW'(500 + i));
    check_first_gap();
    collect_elements(2);
    base = res_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_reset: dp_valid=%b busy=%b, required 0 0", dp_valid, busy);
    end
    sb.delete();
    wr_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (res_count != base) begin
      errors++;
      $display("FAIL run_reset_result: res_valid cycles %0d, required %0d", res_count - base, 0);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    @(negedge clk);
    base = res_count;
    res_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < LEN; i++) send_word(DW'($urandom));
      check_first_gap();
      collect_elements(LEN);
      drain_and_release(0, 1'b1);
    end
    #1;
    checks++;
    if (res_count - base != 2) begin
      errors++;
      $display("FAIL b2b_results: res_valid cycles %0d, required %0d", res_count - base, 2);
    end
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_done_hold();
    test_reset_mid_load();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
